// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - joystick word layout and coin FSM state type
//
// Shared by arcade_input_mux and arcade_coin_pulse.
// Joystick word layout (16 bits per stick):
//   [0] R  [1] L  [2] D  [3] U  [4+:NB] buttons  [4+NB+:NP] start k  [4+NB+NP] coin
package arcade_input_pkg;

    localparam int JOY_R    = 0;
    localparam int JOY_L    = 1;
    localparam int JOY_D    = 2;
    localparam int JOY_U    = 3;
    localparam int JOY_BTN0 = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_state_t;

    function automatic int joy_start_bit(input int nb, input int k);
        return JOY_BTN0 + nb + k;
    endfunction

    function automatic int joy_coin_bit(input int nb, input int np);
        return JOY_BTN0 + nb + np;
    endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// rtl/arcade_coin_pulse.sv - one coin slot: fixed-width pulse, re-arm gap, release wait
//
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous reset, active low
//   ce        in   clock enable; state and counter advance only on ce
//   coin_raw  in   merged raw coin level for this slot
//   inhibit   in   ROM download active; parks the FSM in WAIT_REL and kills the pulse
//   coin_out  out  shaped coin pulse, COIN_PULSE ce ticks wide
module arcade_coin_pulse
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE = 8,
    parameter int COIN_GAP   = 16
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce,
    input  logic coin_raw,
    input  logic inhibit,
    output logic coin_out
);

    localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LEN = CW'(COIN_PULSE);
    localparam logic [CW-1:0] GAP_LEN   = CW'(COIN_GAP);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    coin_state_t     state;
    logic [CW-1:0]   cnt;

    // cnt counts ticks already spent in the current timed state, starting at 1 on
    // entry; it only increments while below its target so it can never wrap.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            coin_out <= 1'b0;
        end else if (inhibit) begin
            // A coin held across the download must be released before it can count.
            state    <= WAIT_REL;
            cnt      <= '0;
            coin_out <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (coin_raw) begin
                        state    <= PULSE;
                        cnt      <= CNT_ONE;
                        coin_out <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt >= PULSE_LEN) begin
                        coin_out <= 1'b0;
                        cnt      <= CNT_ONE;
                        state    <= (COIN_GAP == 0) ? WAIT_REL : GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt >= GAP_LEN) begin
                        state <= WAIT_REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!coin_raw) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_mux.sv
// rtl/arcade_input_mux.sv - joystick words to per-player dir/button/start/coin lines
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous reset, active low
//   ce         in   core clock enable (coin and autofire timing)
//   joy_in     in   16 bits per stick, stick p at [16p+:16]
//   cocktail   in   1 = stick p drives player p, 0 = all sticks merged and mirrored
//   inhibit    in   ROM download active; all outputs forced idle
//   af_mask    in   per-button autofire enable
//   dir_out    out  {U,D,L,R} per player
//   btn_out    out  NUM_BUTTONS per player
//   start_out  out  start k = OR over sticks of the start-k bit
//   coin_out   out  shaped coin pulses, one per slot
// Optional feature: define ARCADE_INPUT_AUTOFIRE_EN to build the autofire gate.
module arcade_input_mux
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 1,
    parameter int NUM_COINS   = 1,
    parameter int COIN_PULSE  = 8,
    parameter int COIN_GAP    = 16,
    parameter int AF_DIV      = 4
) (
    input  logic                               clk_sys,
    input  logic                               reset_n,
    input  logic                               ce,
    input  logic [16*NUM_PLAYERS-1:0]          joy_in,
    input  logic                               cocktail,
    input  logic                               inhibit,
    input  logic [NUM_BUTTONS-1:0]             af_mask,
    output logic [4*NUM_PLAYERS-1:0]           dir_out,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
    output logic [NUM_PLAYERS-1:0]             start_out,
    output logic [NUM_COINS-1:0]               coin_out
);

    localparam int NP       = NUM_PLAYERS;
    localparam int NB       = NUM_BUTTONS;
    localparam int START0   = joy_start_bit(NB, 0);
    localparam int COIN_BIT = joy_coin_bit(NB, NP);

    // Opposing directions cancel each other; the other axis is left alone.
    function automatic logic [3:0] clean_dir(input logic [3:0] d);
        logic r, l, dn, u;
        r  = d[JOY_R] & ~d[JOY_L];
        l  = d[JOY_L] & ~d[JOY_R];
        dn = d[JOY_D] & ~d[JOY_U];
        u  = d[JOY_U] & ~d[JOY_D];
        return {u, dn, l, r};
    endfunction

    logic [COIN_BIT-1:0]  merged;
    logic [4*NP-1:0]      dir_next;
    logic [NB*NP-1:0]     btn_next;
    logic [NP-1:0]        start_next;
    logic [NB-1:0]        af_gate;
    logic [NUM_COINS-1:0] coin_raw;

    always_comb begin
        merged = '0;
        for (int j = 0; j < NP; j++) begin
            merged = merged | joy_in[16*j +: COIN_BIT];
        end
    end

    always_comb begin
        dir_next   = '0;
        btn_next   = '0;
        start_next = '0;
        for (int p = 0; p < NP; p++) begin
            dir_next[4*p +: 4]   = clean_dir(cocktail ? joy_in[16*p + JOY_R +: 4] : merged[JOY_R +: 4]);
            btn_next[NB*p +: NB] = (cocktail ? joy_in[16*p + JOY_BTN0 +: NB] : merged[JOY_BTN0 +: NB])
                                   & af_gate;
            start_next[p]        = merged[START0 + p];
        end
    end

    // Sticks beyond the last coin slot all feed that last slot.
    always_comb begin
        coin_raw = '0;
        for (int j = 0; j < NP; j++) begin
            coin_raw[(j < NUM_COINS) ? j : NUM_COINS - 1] =
                coin_raw[(j < NUM_COINS) ? j : NUM_COINS - 1] | joy_in[16*j + COIN_BIT];
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AFW = $clog2(AF_DIV + 1);
    localparam logic [AFW-1:0] AF_LAST = AFW'(AF_DIV - 1);

    logic [AFW-1:0] af_cnt;
    logic           af_phase;

    // af_phase starts high so a fresh press is seen on the very next clock.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (ce) begin
            if (af_cnt >= AF_LAST) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        af_gate = '1;
        for (int b = 0; b < NB; b++) begin
            af_gate[b] = af_mask[b] ? af_phase : 1'b1;
        end
    end
`else
    // Without autofire every button passes straight through; af_mask has no effect.
    assign af_gate = af_mask | ~af_mask;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_out   <= '0;
            btn_out   <= '0;
            start_out <= '0;
        end else if (inhibit) begin
            dir_out   <= '0;
            btn_out   <= '0;
            start_out <= '0;
        end else begin
            dir_out   <= dir_next;
            btn_out   <= btn_next;
            start_out <= start_next;
        end
    end

    for (genvar c = 0; c < NUM_COINS; c++) begin : g_coin
        arcade_coin_pulse #(
            .COIN_PULSE(COIN_PULSE),
            .COIN_GAP  (COIN_GAP)
        ) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .ce      (ce),
            .coin_raw(coin_raw[c]),
            .inhibit (inhibit),
            .coin_out(coin_out[c])
        );
    end

endmodule

// File: tb/tb_arcade_input_mux.sv
// tb/tb_arcade_input_mux.sv - directed self-checking bench for arcade_input_mux
module tb_arcade_input_mux;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [31:0] joy_in;
    logic        cocktail;
    logic        inhibit;
    logic [0:0]  af_mask;
    logic [7:0]  dir_out;
    logic [1:0]  btn_out;
    logic [1:0]  start_out;
    logic [0:0]  coin_out;

    int total = 0;
    int bad   = 0;
    int highs;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mux #(
        .NUM_PLAYERS(2),
        .NUM_BUTTONS(1),
        .NUM_COINS  (1),
        .COIN_PULSE (8),
        .COIN_GAP   (16),
        .AF_DIV     (4)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .joy_in   (joy_in),
        .cocktail (cocktail),
        .inhibit  (inhibit),
        .af_mask  (af_mask),
        .dir_out  (dir_out),
        .btn_out  (btn_out),
        .start_out(start_out),
        .coin_out (coin_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_count(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (coin_out[0] === 1'b1) h++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b1;
        joy_in   = '0;
        cocktail = 1'b0;
        inhibit  = 1'b0;
        af_mask  = 1'b0;
        #2;
        check("rst_dir", dir_out, 0);
        check("rst_btn", btn_out, 0);
        check("rst_start", start_out, 0);
        check("rst_coin", coin_out, 0);
        ticks(2);
        reset_n = 1'b1;
        ticks(2);

        // Upright: stick1 R mirrored to both players, one clock later
        joy_in = 32'h0001_0000;
        #1;
        check("up_latency", dir_out, 8'h00);
        tick();
        check("up_mirror", dir_out, 8'h11);
        joy_in = 32'h0001_000A;
        tick();
        check("up_clean_rl", dir_out, 8'h88);
        joy_in = 32'h0020_0000;
        tick();
        check("start0_stick1", start_out, 2'b01);
        joy_in = 32'h0000_0040;
        tick();
        check("start1_stick0", start_out, 2'b10);
        joy_in = 32'h0000_0010;
        tick();
        check("up_btn", btn_out, 2'b11);

        // Cocktail routing
        cocktail = 1'b1;
        joy_in   = 32'h0008_0002;
        tick();
        check("ck_route", dir_out, 8'h82);
        joy_in = 32'h0008_0003;
        tick();
        check("ck_clean", dir_out, 8'h80);
        joy_in = 32'h0010_0000;
        tick();
        check("ck_btn", btn_out, 2'b10);
        cocktail = 1'b0;
        joy_in   = '0;
        ticks(2);

        // ce low freezes the coin FSM
        ce     = 1'b0;
        joy_in = 32'h0000_0080;
        tick_count(5, highs);
        check("ce_freeze", highs, 0);
        joy_in = '0;
        tick();
        ce = 1'b1;
        ticks(2);

        // Held coin -> one 8-tick pulse
        joy_in = 32'h0000_0080;
        tick_count(100, highs);
        check("held_width", highs, 8);
        joy_in = '0;
        ticks(2);

        // Re-press during the gap is ignored until release after the gap
        joy_in = 32'h0000_0080;
        tick_count(10, highs);
        check("pulse2_width", highs, 8);
        joy_in = '0;
        ticks(2);
        joy_in = 32'h0000_0080;
        tick_count(30, highs);
        check("gap_repress", highs, 0);
        joy_in = '0;
        ticks(2);
        joy_in = 32'h0080_0000;
        tick_count(10, highs);
        check("rearm_stick1", highs, 8);
        joy_in = '0;
        ticks(30);

        // Coin pressed under inhibit never fires
        inhibit = 1'b1;
        joy_in  = 32'h0000_0081;
        tick_count(5, highs);
        check("inh_coin", highs, 0);
        check("inh_dir", dir_out, 8'h00);
        inhibit = 1'b0;
        tick_count(20, highs);
        check("inh_release_held", highs, 0);
        check("inh_dir_back", dir_out, 8'h11);
        joy_in = '0;
        ticks(2);
        joy_in = 32'h0000_0080;
        tick_count(3, highs);
        check("inh_pre_pulse", highs, 3);
        inhibit = 1'b1;
        tick();
        check("inh_truncate", coin_out, 0);
        inhibit = 1'b0;
        tick_count(20, highs);
        check("inh_no_refire", highs, 0);
        joy_in = '0;
        ticks(2);

        // Asynchronous reset mid-pulse
        joy_in = 32'h0000_0091;
        ticks(3);
        check("pre_rst_coin", coin_out, 1);
        check("pre_rst_dir", dir_out, 8'h11);
        reset_n = 1'b0;
        #1;
        check("arst_coin", coin_out, 0);
        check("arst_dir", dir_out, 0);
        check("arst_btn", btn_out, 0);
        joy_in = '0;
        #1;
        reset_n = 1'b1;
        ticks(3);
        check("post_rst_coin", coin_out, 0);
        check("post_rst_dir", dir_out, 0);

        // Autofire: fire held from reset release
        reset_n = 1'b0;
        #1;
        joy_in  = 32'h0000_0010;
        af_mask = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            check($sformatf("af_%0d", i), btn_out, (((i / 4) % 2) == 0) ? 2'b11 : 2'b00);
`else
            check($sformatf("af_%0d", i), btn_out, 2'b11);
`endif
        end
        af_mask = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("af_off_%0d", i), btn_out, 2'b11);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
